// File: rtl/signed_comp_seq.sv
// Registered MSB-first magnitude comparator, DIGIT bits per cycle, early exit on first differing digit.
// Signed mode flips the sign bit of both operands so that a plain unsigned scan orders them correctly.
module signed_comp_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             greater,
  output logic             smaller,
  output logic             equal,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [IW-1:0]    r_idx;
  logic             r_resValid;
  logic             r_greater;
  logic             r_smaller;
  logic             r_equal;

  logic [DIGIT-1:0] w_digA;
  logic [DIGIT-1:0] w_digB;
  logic [WIDTH-1:0] w_signMask;

  assign w_signMask = {signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_digA = r_opA[int'(r_idx)*DIGIT +: DIGIT];
    w_digB = r_opB[int'(r_idx)*DIGIT +: DIGIT];
  end

  // Operands are stored already sign-mapped, so the scan itself is always unsigned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_idx      <= '0;
      r_resValid <= 1'b0;
      r_greater  <= 1'b0;
      r_smaller  <= 1'b0;
      r_equal    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_opA   <= a ^ w_signMask;
            r_opB   <= b ^ w_signMask;
            r_idx   <= IW'(N-1);
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_digA != w_digB) begin
            r_greater  <= (w_digA > w_digB);
            r_smaller  <= (w_digA < w_digB);
            r_equal    <= 1'b0;
            r_resValid <= 1'b1;
            r_state    <= DONE;
          end else if (r_idx == '0) begin
            r_equal    <= 1'b1;
            r_resValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            r_greater  <= 1'b0;
            r_smaller  <= 1'b0;
            r_equal    <= 1'b0;
            r_resValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign res_valid   = r_resValid;
  assign greater     = r_greater;
  assign smaller     = r_smaller;
  assign equal       = r_equal;

endmodule

// File: tb/tb_signed_comp_seq.sv
// Directed and random checks of signed_comp_seq for DIGIT=4, DIGIT=1 and DIGIT=16 builds.
module tb_signed_comp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        signedMode = 1'b0;
  logic [2:0]  startValid = '0;
  logic [2:0]  resReady = '0;
  logic [2:0]  startReady, resValid, greater, smaller, equal, busy;

  int checksTotal = 0;
  int checksPassed = 0;

  always #5 clk = ~clk;

  signed_comp_seq #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(startValid[0]), .start_ready(startReady[0]),
    .a(opA), .b(opB), .signed_mode(signedMode), .res_valid(resValid[0]), .res_ready(resReady[0]),
    .greater(greater[0]), .smaller(smaller[0]), .equal(equal[0]), .busy(busy[0]));

  signed_comp_seq #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(startValid[1]), .start_ready(startReady[1]),
    .a(opA), .b(opB), .signed_mode(signedMode), .res_valid(resValid[1]), .res_ready(resReady[1]),
    .greater(greater[1]), .smaller(smaller[1]), .equal(equal[1]), .busy(busy[1]));

  signed_comp_seq #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(startValid[2]), .start_ready(startReady[2]),
    .a(opA), .b(opB), .signed_mode(signedMode), .res_valid(resValid[2]), .res_ready(resReady[2]),
    .greater(greater[2]), .smaller(smaller[2]), .equal(equal[2]), .busy(busy[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [2:0]  gse;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] refCmp(input logic [15:0] x, input logic [15:0] y, input logic m);
    logic g, s;
    g = m ? ($signed(x) > $signed(y)) : (x > y);
    s = m ? ($signed(x) < $signed(y)) : (x < y);
    return {g, s, (x == y)};
  endfunction

  function automatic int refLat(input logic [15:0] x, input logic [15:0] y, input int dig);
    logic [31:0] diff;
    logic [31:0] mask;
    int n;
    diff = {16'h0, x ^ y};
    mask = (32'h1 << dig) - 32'h1;
    n = 16 / dig;
    for (int k = 1; k <= n; k++)
      if (((diff >> (16 - k*dig)) & mask) != 0) return k;
    return n;
  endfunction

  // Presents an operation and completes the accept edge.
  task automatic applyStimulus(input int w, input logic [15:0] x, input logic [15:0] y, input logic m);
    @(negedge clk);
    opA = x;
    opB = y;
    signedMode = m;
    startValid[w] = 1'b1;
    checkOutput("start_ready before accept", {31'h0, startReady[w]}, 32'h1);
    @(posedge clk);
    #1;
    startValid[w] = 1'b0;
    opA = ~x;
    opB = ~y;
  endtask

  task automatic waitResult(input int w, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (resValid[w]) break;
    end
    if (!resValid[w]) checkOutput("result timeout", 32'h0, 32'h1);
  endtask

  task automatic releaseResult(input int w);
    @(negedge clk);
    resReady[w] = 1'b1;
    @(posedge clk);
    #1;
    resReady[w] = 1'b0;
    checkOutput("idle after release", {28'h0, startReady[w], resValid[w], busy[w],
                (greater[w] | smaller[w] | equal[w])}, 32'h8);
  endtask

  task automatic runOp(input int w, input logic [15:0] x, input logic [15:0] y, input logic m,
                       input logic [2:0] expGse, input int expLat, input string tag);
    int lat;
    applyStimulus(w, x, y, m);
    waitResult(w, lat);
    checkOutput({tag, " gse"}, {29'h0, greater[w], smaller[w], equal[w]}, {29'h0, expGse});
    checkOutput({tag, " latency"}, lat, expLat);
    releaseResult(w);
  endtask

  initial begin
    logic [2:0]  heldGse;
    logic [15:0] rx, ry;
    logic        rm;
    int          lat;

    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 1};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1};
    vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1};
    vecs[3]  = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
    vecs[4]  = '{16'h1234, 16'h1234, 1'b1, 3'b001, 4};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b0, 3'b001, 4};
    vecs[6]  = '{16'h1334, 16'h1234, 1'b0, 3'b100, 2};
    vecs[7]  = '{16'h1234, 16'h1235, 1'b0, 3'b010, 4};
    vecs[8]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
    vecs[9]  = '{16'hFFFE, 16'hFFFF, 1'b1, 3'b010, 4};
    vecs[10] = '{16'h0000, 16'hFFFF, 1'b1, 3'b100, 1};
    vecs[11] = '{16'h1200, 16'h1210, 1'b0, 3'b010, 3};

    #2;
    for (int w = 0; w < 3; w++)
      checkOutput("reset state", {27'h0, startReady[w], resValid[w], busy[w], greater[w],
                  smaller[w] | equal[w]}, 32'h10);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      runOp(0, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].gse, vecs[i].lat, $sformatf("vec%0d", i));

    // Result held in DONE while the producer side toggles.
    applyStimulus(0, 16'h1234, 16'h1235, 1'b1);
    waitResult(0, lat);
    heldGse = {greater[0], smaller[0], equal[0]};
    checkOutput("hold gse initial", {29'h0, heldGse}, 32'h2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      startValid[0] = ~startValid[0];
      opA = opA + 16'h1111;
      opB = opB - 16'h0101;
      @(posedge clk);
      #1;
      checkOutput("hold outputs", {26'h0, startReady[0], resValid[0], busy[0],
                  greater[0], smaller[0], equal[0]}, 32'h1A);
    end
    @(negedge clk);
    startValid[0] = 1'b0;
    releaseResult(0);

    // Asynchronous reset in the middle of a scan.
    applyStimulus(0, 16'h1234, 16'h1235, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", {26'h0, startReady[0], resValid[0], busy[0],
                greater[0], smaller[0], equal[0]}, 32'h20);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("no result after abort", {31'h0, resValid[0]}, 32'h0);
    end
    runOp(0, 16'hA000, 16'h0005, 1'b1, 3'b010, 1, "post-reset op");

    for (int w = 1; w < 3; w++) begin
      for (int i = 0; i < 1000; i++) begin
        rx = 16'($urandom);
        ry = (i % 8 == 0) ? rx : 16'($urandom);
        if (i % 5 == 1) ry = rx ^ (16'h1 << $urandom_range(15, 0));
        rm = 1'($urandom);
        runOp(w, rx, ry, rm, refCmp(rx, ry, rm), refLat(rx, ry, (w == 1) ? 1 : 16),
              $sformatf("rand d%0d #%0d", (w == 1) ? 1 : 16, i));
      end
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
